// File: rtl/serial_adder_pkg.sv
// Shared types and limits for the bit-serial adder.
package serial_adder_pkg;

   // Largest operand width the adder is built for.
   localparam int unsigned MAX_WIDTH = 64;

   // Control states: idle, one bit per cycle, single-cycle completion.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

   // Bit counter width for a given operand width (never below one bit).
   function automatic int unsigned cnt_width(input int unsigned w);
      int unsigned cw;
      cw = $clog2(w + 1);
      return (cw < 1) ? 1 : cw;
   endfunction

endpackage

// File: rtl/serial_adder_full_adder.sv
// Single-bit full adder cell used by the serial adder datapath.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (b & cin) | (a & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: a + b + cin over WIDTH cycles, LSB first, one FA cell.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int unsigned      CNT_W = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

   if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_width_check
      $error("serial_adder: WIDTH out of supported range");
   end

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] res_sh_q, res_sh_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             fa_sum, fa_cout;
   logic [WIDTH-1:0] res_next;

   full_adder u_fa (
      .a    (a_sh_q[0]),
      .b    (b_sh_q[0]),
      .cin  (carry_q),
      .sum  (fa_sum),
      .cout (fa_cout)
   );

   // Result shift register with the new FA sum entering at the MSB;
   // written as a shift/or so that WIDTH=1 needs no empty slice.
   assign res_next = (res_sh_q >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));

   assign busy = (state_q == SHIFT);
   assign done = (state_q == DONE);
   assign sum  = sum_q;
   assign cout = cout_q;

   // Next-state and datapath update; DONE accepts start like IDLE.
   always_comb begin
      state_d  = state_q;
      a_sh_d   = a_sh_q;
      b_sh_d   = b_sh_q;
      res_sh_d = res_sh_q;
      carry_d  = carry_q;
      cnt_d    = cnt_q;
      sum_d    = sum_q;
      cout_d   = cout_q;
      unique case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (start) begin
               a_sh_d   = a;
               b_sh_d   = b;
               carry_d  = cin;
               res_sh_d = '0;
               cnt_d    = '0;
               state_d  = SHIFT;
            end
         end
         SHIFT: begin
            a_sh_d   = a_sh_q >> 1;
            b_sh_d   = b_sh_q >> 1;
            res_sh_d = res_next;
            carry_d  = fa_cout;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               sum_d   = res_next;
               cout_d  = fa_cout;
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Datapath registers: operand/result shifters, carry, counter, outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         res_sh_q <= '0;
         carry_q  <= 1'b0;
         cnt_q    <= '0;
         sum_q    <= '0;
         cout_q   <= 1'b0;
      end else begin
         a_sh_q   <= a_sh_d;
         b_sh_q   <= b_sh_d;
         res_sh_q <= res_sh_d;
         carry_q  <= carry_d;
         cnt_q    <= cnt_d;
         sum_q    <= sum_d;
         cout_q   <= cout_d;
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8 and WIDTH=1 instances).
module tb_serial_adder;

   logic       clk = 1'b0;
   logic       rst;
   logic       start8, cin8, busy8, done8, cout8;
   logic [7:0] a8, b8, sum8;
   logic       start1, a1, b1, cin1, busy1, done1, sum1, cout1;

   int unsigned errors = 0;
   int unsigned checks = 0;
   logic [8:0]  last8;   // reference: last completed {cout,sum} of the 8-bit unit

   always #5 clk = ~clk;

   serial_adder #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
      .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
   );

   serial_adder #(.WIDTH(1)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
      .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Present a request at the current negedge; accepted at the next posedge.
   task automatic drive8(input logic [7:0] ia, input logic [7:0] ib, input logic ic);
      start8 = 1'b1; a8 = ia; b8 = ib; cin8 = ic;
   endtask

   // Follow one operation to its done cycle; optionally poke start while busy.
   task automatic finish8(input string tag, input logic [8:0] exp, input int poke_at);
      int n      = 1;
      int busy_n = 0;
      @(negedge clk);
      start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      while (done8 !== 1'b1 && n < 40) begin
         if (busy8 === 1'b1) busy_n++;
         check({tag, "/hold"}, {cout8, sum8}, last8);
         if (n == poke_at) begin
            start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55;
         end else begin
            start8 = 1'b0;
         end
         @(negedge clk);
         n++;
      end
      start8 = 1'b0;
      check({tag, "/latency"}, n, 9);
      check({tag, "/busy_cycles"}, busy_n, 8);
      check({tag, "/busy_in_done"}, busy8, 0);
      check({tag, "/result"}, {cout8, sum8}, exp);
      last8 = exp;
   endtask

   task automatic idle8(input string tag);
      @(negedge clk);
      check({tag, "/done_single"}, done8, 0);
      check({tag, "/idle_busy"}, busy8, 0);
      check({tag, "/idle_hold"}, {cout8, sum8}, last8);
   endtask

   task automatic op1(input int v);
      logic ia, ib, ic;
      int   n = 1;
      ia = 1'(v); ib = 1'(v >> 1); ic = 1'(v >> 2);
      start1 = 1'b1; a1 = ia; b1 = ib; cin1 = ic;
      @(negedge clk);
      start1 = 1'b0; a1 = ~ia; b1 = ~ib; cin1 = ~ic;
      check("w1/busy", busy1, 1);
      while (done1 !== 1'b1 && n < 10) begin
         @(negedge clk);
         n++;
      end
      check("w1/latency", n, 2);
      check("w1/result", {cout1, sum1}, 2'(ia) + 2'(ib) + 2'(ic));
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
      start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
      last8 = '0;
      repeat (2) @(negedge clk);
      check("reset/busy8", busy8, 0);
      check("reset/done8", done8, 0);
      check("reset/res8", {cout8, sum8}, 0);
      check("reset/busy1", busy1, 0);
      check("reset/done1", done1, 0);
      check("reset/res1", {cout1, sum1}, 0);
      rst = 1'b0;
      @(negedge clk);

      drive8(8'h25, 8'h1A, 1'b0); finish8("t1", 9'h03F, 0); idle8("t1");
      drive8(8'hFF, 8'h01, 1'b0); finish8("t2", 9'h100, 0); idle8("t2");
      drive8(8'hFF, 8'hFF, 1'b1); finish8("t3", 9'h1FF, 0);
      drive8(8'h01, 8'h02, 1'b0); finish8("t3b2b", 9'h003, 0); idle8("t3b2b");
      drive8(8'h10, 8'h20, 1'b0); finish8("t4", 9'h030, 3); idle8("t4");

      // Asynchronous reset after four SHIFT cycles, away from any clock edge.
      drive8(8'h7F, 8'h01, 1'b0);
      @(negedge clk);
      start8 = 1'b0;
      repeat (4) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("rst/busy", busy8, 0);
      check("rst/done", done8, 0);
      check("rst/res", {cout8, sum8}, 0);
      @(negedge clk);
      rst = 1'b0;
      last8 = '0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("rst/no_done", done8, 0);
      end
      drive8(8'h02, 8'h03, 1'b0); finish8("t5", 9'h005, 0); idle8("t5");

      for (int i = 0; i < 24; i++) begin
         logic [7:0] ra, rb;
         logic       rc;
         ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
         drive8(ra, rb, rc);
         finish8("rnd", {1'b0, ra} + {1'b0, rb} + 9'(rc), 0);
         if ($urandom_range(1, 0) == 0) idle8("rnd");
      end
      idle8("end");

      for (int v = 0; v < 8; v++) op1(v);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
